// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux_rr channel multiplexer.
package stream_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // A channel tag must be at least one bit wide, even when $clog2 would give 0.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found at or after ptr.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [2*N_CH-1:0] req2;

  // The request vector is doubled so the wrap-around search becomes a linear scan from ptr.
  always_comb begin
    req2       = {req, req};
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    for (int j = 0; j < 2*N_CH; j++) begin
      if (!gnt_any && (j >= int'(ptr)) && req2[j]) begin
        gnt_any    = 1'b1;
        gnt_idx    = (j >= N_CH) ? SEL_W'(j - N_CH) : SEL_W'(j);
        gnt_onehot = N_CH'(1) << ((j >= N_CH) ? (j - N_CH) : j);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with registered output, selecting either by
// the sel port or by a round-robin arbiter; each output word carries its source tag.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = clog2_min1(N_CH),
  parameter int MODE  = MODE_SEL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N_CH-1:0]  arb_onehot;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_any;

  logic [N_CH-1:0]  sel_onehot;
  logic             sel_any;

  logic [N_CH-1:0]  gnt_onehot;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [W-1:0]     gnt_data;
  logic             load_ok;
  logic             transfer;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req        (in_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  // A select value beyond the last channel never matches, so it yields no grant.
  always_comb begin
    sel_onehot = '0;
    sel_any    = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if ((SEL_W'(k) == sel) && in_valid[k]) begin
        sel_onehot[k] = 1'b1;
        sel_any       = 1'b1;
      end
    end
  end

  always_comb begin
    if (MODE == MODE_RR) begin
      gnt_onehot = arb_onehot;
      gnt_idx    = arb_idx;
      gnt_any    = arb_any;
    end else begin
      gnt_onehot = sel_onehot;
      gnt_idx    = sel;
      gnt_any    = sel_any;
    end

    gnt_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (SEL_W'(k) == gnt_idx) gnt_data = in_data[k*W +: W];
    end

    load_ok  = !out_valid_q || out_ready;
    transfer = load_ok && gnt_any && !rst;
    in_ready = transfer ? gnt_onehot : '0;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (transfer) begin
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      if (MODE == MODE_RR) begin
        rr_ptr_d = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a select-mode and a round-robin instance run side by side
// against a transaction-level reference model; a 3-channel instance covers sel >= N_CH.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // index 0: MODE_SEL instance, index 1: MODE_RR instance
  logic [31:0] idat [2];
  logic [3:0]  iv   [2];
  logic        ordy [2];
  logic [1:0]  sel_s;

  logic [3:0]  s_rdy, r_rdy;
  logic [7:0]  s_od, r_od;
  logic [1:0]  s_ch, r_ch, r_sel_unused;
  logic        s_ov, r_ov;

  logic [23:0] n3_dat;
  logic [2:0]  n3_iv, n3_rdy;
  logic [1:0]  n3_sel, n3_ch;
  logic [7:0]  n3_od;
  logic        n3_ov, n3_ordy;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic       m_vld  [2];
  logic [7:0] m_data [2];
  int         m_ch   [2];
  int         m_ptr  [2];

  assign r_sel_unused = sel_s;

  stream_mux_rr #(.N_CH(4), .W(8), .MODE(0)) u_sel (
    .clk(clk), .rst(rst), .in_data(idat[0]), .in_valid(iv[0]), .in_ready(s_rdy),
    .sel(sel_s), .out_data(s_od), .out_ch(s_ch), .out_valid(s_ov), .out_ready(ordy[0]));

  stream_mux_rr #(.N_CH(4), .W(8), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(idat[1]), .in_valid(iv[1]), .in_ready(r_rdy),
    .sel(r_sel_unused), .out_data(r_od), .out_ch(r_ch), .out_valid(r_ov), .out_ready(ordy[1]));

  stream_mux_rr #(.N_CH(3), .W(8), .MODE(0)) u_n3 (
    .clk(clk), .rst(rst), .in_data(n3_dat), .in_valid(n3_iv), .in_ready(n3_rdy),
    .sel(n3_sel), .out_data(n3_od), .out_ch(n3_ch), .out_valid(n3_ov), .out_ready(n3_ordy));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel that wins under the stated rules, or -1 when nobody is granted.
  function automatic int exp_grant(input int d, input logic [3:0] v, input int s, input int ptr);
    if (d == 0) return v[s] ? s : -1;
    for (int i = 0; i < 4; i++) begin
      if (v[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return -1;
  endfunction

  // One clock cycle: check in_ready before the edge, advance the model, check outputs after.
  task automatic step();
    int         g    [2];
    logic [3:0] er   [2];
    logic [3:0] rdyv [2];
    #1;
    rdyv[0] = s_rdy;
    rdyv[1] = r_rdy;
    for (int d = 0; d < 2; d++) begin
      g[d]  = exp_grant(d, iv[d], int'(sel_s), m_ptr[d]);
      er[d] = (!rst && (!m_vld[d] || ordy[d]) && g[d] >= 0) ? (4'b0001 << g[d]) : 4'b0000;
      check(d == 0 ? "sel_in_ready" : "rr_in_ready", {28'b0, rdyv[d]}, {28'b0, er[d]});
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_vld[d] = 1'b0; m_data[d] = 8'h00; m_ch[d] = 0; m_ptr[d] = 0;
      end else if (er[d] != 4'b0000) begin
        m_vld[d]  = 1'b1;
        m_data[d] = 8'(idat[d] >> (8 * g[d]));
        m_ch[d]   = g[d];
        if (d == 1) m_ptr[d] = (g[d] + 1) % 4;
      end else if (ordy[d]) begin
        m_vld[d] = 1'b0;
      end
    end
    #1;
    check("sel_out_valid", {31'b0, s_ov}, {31'b0, m_vld[0]});
    check("sel_out_data",  {24'b0, s_od}, {24'b0, m_data[0]});
    check("sel_out_ch",    {30'b0, s_ch}, 32'(m_ch[0]));
    check("rr_out_valid",  {31'b0, r_ov}, {31'b0, m_vld[1]});
    check("rr_out_data",   {24'b0, r_od}, {24'b0, m_data[1]});
    check("rr_out_ch",     {30'b0, r_ch}, 32'(m_ch[1]));
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_vld[d] = 1'b0; m_data[d] = 8'h00; m_ch[d] = 0; m_ptr[d] = 0;
      idat[d] = 32'h0; iv[d] = 4'hF; ordy[d] = 1'b1;
    end
    sel_s = 2'd0;
    n3_dat = 24'hCCBBAA; n3_iv = 3'b111; n3_sel = 2'd3; n3_ordy = 1'b1;

    // reset held two cycles with every channel valid
    rst = 1'b1;
    step();
    step();
    check("rst_sel_valid", {31'b0, s_ov}, 32'd0);
    check("rst_rr_data",   {24'b0, r_od}, 32'd0);
    rst = 1'b0;

    // select mode walks channels 0..3
    idat[0] = 32'hD3C2B1A0; iv[0] = 4'hF;
    iv[1] = 4'h0;
    for (int s = 0; s < 4; s++) begin
      sel_s = 2'(s);
      step();
      check("t2_data", {24'b0, s_od}, 32'hA0 + 32'h11 * s);
      check("t2_ch",   {30'b0, s_ch}, 32'(s));
    end

    // selected channel not valid: no grant until it is raised
    sel_s = 2'd2; iv[0] = 4'b1011;
    step();
    step();
    check("t3_idle_valid", {31'b0, s_ov}, 32'd0);
    iv[0] = 4'b1111;
    step();
    check("t3_ch", {30'b0, s_ch}, 32'd2);

    // round robin, all valid, eight cycles
    idat[1] = 32'h44332211; iv[1] = 4'hF;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t4_ch",    {30'b0, r_ch}, 32'(i % 4));
      check("t4_valid", {31'b0, r_ov}, 32'd1);
    end

    // sparse valids skip without bubbles, then a stall
    iv[1] = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_ch", {30'b0, r_ch}, (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    ordy[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_stall_ch",   {30'b0, r_ch}, 32'd3);
      check("t5_stall_data", {24'b0, r_od}, 32'h44);
    end
    ordy[1] = 1'b1;
    step();
    check("t5_resume_ch", {30'b0, r_ch}, 32'd1);

    // reset during a stall drops the held word; arbitration restarts at channel 0
    step();
    ordy[1] = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("t6_rst_valid", {31'b0, r_ov}, 32'd0);
    rst = 1'b0; ordy[1] = 1'b1;
    step();
    check("t6_first_ch", {30'b0, r_ch}, 32'd1);

    // three-channel instance: sel = 3 is out of range
    n3_sel = 2'd3;
    #1;
    check("n3_oob_ready", {29'b0, n3_rdy}, 32'd0);
    step();
    check("n3_oob_valid", {31'b0, n3_ov}, 32'd0);
    n3_sel = 2'd1;
    #1;
    check("n3_ready", {29'b0, n3_rdy}, 32'b010);
    step();
    check("n3_data", {24'b0, n3_od}, 32'hBB);
    check("n3_ch",   {30'b0, n3_ch}, 32'd1);

    // randomized traffic on both instances
    for (int i = 0; i < 80; i++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d]   = 4'($urandom);
        idat[d] = $urandom;
        ordy[d] = ($urandom_range(0, 3) != 0);
      end
      sel_s = 2'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
